// File: rtl/pipe_alu_pkg.sv
// Shared definitions for pipe_alu: function codes, FSM states and the result-flag payload.
package pipe_alu_pkg;

  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_OR  = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_MUL = 3'b011;
  localparam logic [2:0] F_XOR = 3'b100;
  localparam logic [2:0] F_NOR = 3'b101;
  localparam logic [2:0] F_SUB = 3'b110;
  localparam logic [2:0] F_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VALID    = 2'd1,
    MUL_BUSY = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } alu_flags_t;

endpackage

// File: rtl/pipe_alu_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of the product.
// The last bit is folded in combinationally so the product is ready on the WIDTH-th edge.
module pipe_alu_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done_c,
  output logic [WIDTH-1:0] o_product_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;

  assign w_addend    = r_mplier[0] ? r_mcand : '0;
  assign w_sum       = r_acc + w_addend;
  assign o_done_c    = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign o_product_c = w_sum;
  assign o_busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (o_done_c) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_alu.sv
// Pipelined ALU with valid/ready handshake and registered result/flags.
// Define PIPE_ALU_MUL_EN to build the iterative multiplier; otherwise MUL returns 0 in one cycle.
module pipe_alu
  import pipe_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_out_valid;
  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] r_res;
  alu_flags_t       r_flags;

  logic             w_accept;
  logic             w_out_fire;
  logic             w_load;
  logic             w_is_mul;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_alu_res;
  alu_flags_t       w_alu_flags;
  logic [WIDTH-1:0] w_res_nxt;
  alu_flags_t       w_flags_nxt;
  logic [WIDTH:0]   w_add_ext;
  logic [WIDTH:0]   w_sub_ext;

  assign in_ready   = (r_state != MUL_BUSY) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // Subtraction as a + ~b + 1 so the carry-out reads directly as "no borrow".
  assign w_add_ext = {1'b0, a} + {1'b0, b};
  assign w_sub_ext = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);

  always_comb begin
    w_alu_res   = '0;
    w_alu_flags = '0;
    case (f)
      F_AND: w_alu_res = a & b;
      F_OR:  w_alu_res = a | b;
      F_ADD: begin
        w_alu_res         = w_add_ext[WIDTH-1:0];
        w_alu_flags.carry = w_add_ext[WIDTH];
        w_alu_flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      F_MUL: w_alu_res = '0;
      F_XOR: w_alu_res = a ^ b;
      F_NOR: w_alu_res = ~(a | b);
      F_SUB: begin
        w_alu_res         = w_sub_ext[WIDTH-1:0];
        w_alu_flags.carry = w_sub_ext[WIDTH];
        w_alu_flags.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      F_SLT: w_alu_res = WIDTH'($signed(a) < $signed(b));
    endcase
    w_alu_flags.zero = (w_alu_res == '0);
  end

`ifdef PIPE_ALU_MUL_EN
  logic             w_mul_start;
  logic             w_mul_busy;
  logic [WIDTH-1:0] w_mul_product;

  assign w_is_mul    = (f == F_MUL);
  assign w_mul_start = w_accept && w_is_mul;

  pipe_alu_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_mul_start),
    .i_a        (a),
    .i_b        (b),
    .o_busy     (w_mul_busy),
    .o_done_c   (w_mul_done),
    .o_product_c(w_mul_product)
  );

  // While iterating, the register load comes from the multiplier, not the live ALU inputs.
  always_comb begin
    w_res_nxt   = w_alu_res;
    w_flags_nxt = w_alu_flags;
    if (w_mul_busy) begin
      w_res_nxt         = w_mul_product;
      w_flags_nxt       = '0;
      w_flags_nxt.zero  = (w_mul_product == '0);
    end
  end
`else
  assign w_is_mul    = 1'b0;
  assign w_mul_done  = 1'b0;
  assign w_res_nxt   = w_alu_res;
  assign w_flags_nxt = w_alu_flags;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = r_out_valid;
    w_load          = 1'b0;
    case (r_state)
      IDLE, VALID: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_state_nxt     = MUL_BUSY;
            w_out_valid_nxt = 1'b0;
          end else begin
            w_state_nxt     = VALID;
            w_out_valid_nxt = 1'b1;
            w_load          = 1'b1;
          end
        end else if (w_out_fire) begin
          w_state_nxt     = IDLE;
          w_out_valid_nxt = 1'b0;
        end
      end
      MUL_BUSY: begin
        if (w_mul_done) begin
          w_state_nxt     = VALID;
          w_out_valid_nxt = 1'b1;
          w_load          = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_flags     <= '0;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      if (w_load) begin
        r_res   <= w_res_nxt;
        r_flags <= w_flags_nxt;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign r         = r_res;
  assign zero      = r_flags.zero;
  assign carry     = r_flags.carry;
  assign ovf       = r_flags.ovf;

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be >= 4.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 f  input  3  function code.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 r  output  WIDTH  result.
REQ-012 zero, carry, ovf  output  1 each  result flags.

Function
REQ-013 Codes: 000 AND, 001 OR, 010 ADD, 011 MUL, 100 XOR, 101 NOR, 110 SUB (a-b), 111 SLT (signed, r=1 if a<b else 0).
REQ-014 Request accepted only when in_valid && in_ready at a rising edge.
REQ-015 in_ready = (state != MUL_BUSY) && (!out_valid || out_ready).
REQ-016 Non-MUL ops: result and flags registered; out_valid high the cycle after acceptance (latency 1, throughput 1).
REQ-017 out_valid, r, and flags stay stable until out_valid && out_ready.
REQ-018 Simultaneous acceptance of output and new request: new result replaces old next cycle, out_valid stays high.
REQ-019 Output accepted with no new request: out_valid low next cycle.
REQ-020 zero = (r == 0) for every op.
REQ-021 carry = carry-out of ADD; for SUB, carry = 1 when no borrow (a >= b unsigned); 0 for other ops.
REQ-022 ovf = signed overflow of ADD/SUB; 0 for other ops.
REQ-023 Arithmetic modulo 2^WIDTH; MUL returns low WIDTH bits of a*b.
REQ-024 FSM states: IDLE (no result pending), VALID (out_valid high), MUL_BUSY (iterating).
REQ-025 Transitions: IDLE/VALID --accept MUL--> MUL_BUSY; MUL_BUSY --iteration WIDTH done--> VALID; VALID --output accepted, no new request--> IDLE; IDLE --accept non-MUL--> VALID.
REQ-026 MUL is shift-add, one bit per cycle; out_valid rises exactly WIDTH cycles after acceptance.
REQ-027 During MUL_BUSY in_ready is 0 and out_valid is 0.

Reset
REQ-028 On rst_n low, immediately: state IDLE, out_valid 0, r 0, zero 0, carry 0, ovf 0, multiplier registers cleared.
REQ-029 Reset mid-MUL aborts the operation; no result is produced.
REQ-030 in_ready is 1 the first cycle after rst_n deasserts.

Configuration
REQ-031 Macro PIPE_ALU_MUL_EN: when defined, MUL follows REQ-026.
REQ-032 When not defined: no multiplier logic is built; f=011 completes with latency 1, r=0, zero=1, carry=0, ovf=0; MUL_BUSY is never entered.

Structure
REQ-033 Package pipe_alu_pkg holds the function-code constants and the FSM state typedef.
REQ-034 Sub-module pipe_alu_mul (iterative multiplier: start, busy, done, product) is instantiated only under PIPE_ALU_MUL_EN.

Verification (WIDTH=32 unless stated)
REQ-035 ADD a=0xFFFFFFFF b=1, out_ready=1 -> next cycle r=0, zero=1, carry=1, ovf=0.
REQ-036 SUB a=0x80000000 b=1 -> r=0x7FFFFFFF, ovf=1, carry=1; SLT a=-5 b=3 -> r=1.
REQ-037 Back-to-back ADDs (1+2, 3+4, 5+6) with out_ready=1 -> r=3,7,11 on consecutive cycles, in_ready held 1.
REQ-038 out_ready=0 for 3 cycles after AND 0xF0F0 & 0xFF00 -> r=0xF000 held, in_ready=0 until accepted.
REQ-039 MUL_EN defined, MUL 1234*5678 -> out_valid exactly 32 cycles later, r=7006652, in_ready=0 meanwhile; repeat with rst_n pulsed at cycle 10 -> out_valid never rises, in_ready=1 after reset.
REQ-040 MUL_EN undefined, WIDTH=8, MUL 7*9 -> next cycle r=0, zero=1.
